// File: rtl/arb_req_stage_8ch.sv
// Request-staging stage for the 8-requester hierarchical arbiter.
// Each channel has its own burst-descriptor FIFO, and every non-empty FIFO
// raises its req bit. A granted channel's burst is streamed as a locked beat
// sequence, and all requests stay masked until the last beat is accepted.
module arb_req_stage_8ch #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*LEN_W-1:0] in_len,
  output logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       grant,
  output logic                 out_valid,
  output logic [2:0]           out_ch,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [LEN_W-1:0] mem_q [NCH][DEPTH];
  logic [LEN_W-1:0] mem_d [NCH][DEPTH];
  logic [PW-1:0]    rd_ptr_q [NCH];
  logic [PW-1:0]    rd_ptr_d [NCH];
  logic [PW-1:0]    wr_ptr_q [NCH];
  logic [PW-1:0]    wr_ptr_d [NCH];
  logic [CW-1:0]    count_q  [NCH];
  logic [CW-1:0]    count_d  [NCH];

  logic [NCH-1:0]   push, pop, nonempty;
  logic [2:0]       gnt_idx;
  logic             gnt_multi, gnt_hit;

  // Requests are visible only in IDLE, so the arbiter never re-grants mid-burst.
  always_comb begin
    nonempty = '0;
    for (int unsigned i = 0; i < NCH; i++) nonempty[i] = (count_q[i] != '0);
    req = (state_q == IDLE) ? nonempty : '0;
  end

  // Decode the grant vector: index of the set bit and whether more than one is set.
  always_comb begin
    gnt_idx   = '0;
    gnt_multi = ((grant & (grant - NCH'(1))) != '0);
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) gnt_idx = 3'(i);
    end
    gnt_hit = !gnt_multi && ((grant & req) != '0);
  end

  // Burst FSM: accept one valid grant in IDLE, then count beats down in BURST.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pop     = '0;
    case (state_q)
      IDLE: begin
        if (gnt_multi) begin
          err_d = 1'b1;
        end else if (gnt_hit) begin
          state_d      = BURST;
          ch_d         = gnt_idx;
          cnt_d        = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
          pop[gnt_idx] = 1'b1;
        end
      end
      BURST: begin
        if (out_ready) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel descriptor FIFOs; readiness comes from the registered count,
  // so a full FIFO refuses a push even when it is popped in the same cycle.
  always_comb begin
    in_ready = '0;
    push     = '0;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      in_ready[i] = (count_q[i] < CW'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_len[i*LEN_W +: LEN_W];
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign out_valid = (state_q == BURST);
  assign busy      = (state_q == BURST);
  assign out_ch    = (state_q == BURST) ? ch_q : '0;
  assign out_last  = (state_q == BURST) && (cnt_q == '0);
  assign err       = err_q;

endmodule

// File: tb/tb_arb_req_stage_8ch.sv
// Testbench for arb_req_stage_8ch. Queue-based reference model plus directed
// scenarios and randomized arbiter-style traffic.
module tb_arb_req_stage_8ch;

  localparam int unsigned NCH   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*LEN_W-1:0] in_len;
  logic [NCH-1:0]       req;
  logic [NCH-1:0]       grant;
  logic                 out_valid;
  logic [2:0]           out_ch;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;
  logic                 err;

  always #5 clk = ~clk;

  arb_req_stage_8ch #(.NCH(NCH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_len(in_len), .req(req), .grant(grant), .out_valid(out_valid),
    .out_ch(out_ch), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: descriptor queues, owner, beats left in the burst.
  int unsigned mq [NCH][$];
  bit          m_busy;
  int unsigned m_owner;
  int unsigned m_left;
  bit          m_err;
  bit          m_live = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] m_req();
    logic [NCH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k] = !m_busy && (mq[k].size() != 0);
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_rdy();
    logic [NCH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k] = (mq[k].size() < DEPTH);
    return r;
  endfunction

  task automatic check_outputs();
    check("in_ready",  in_ready,  m_rdy());
    check("req",       req,       m_req());
    check("out_valid", out_valid, m_busy);
    check("out_ch",    out_ch,    m_busy ? m_owner : 0);
    check("out_last",  out_last,  m_busy && (m_left == 1));
    check("busy",      busy,      m_busy);
    check("err",       err,       m_err);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic [NCH-1:0] iv, input logic [31:0] lens,
                      input logic [NCH-1:0] gr, input logic ordy, input logic rn);
    logic [NCH-1:0] rdy, rq;
    @(negedge clk);
    in_valid  = iv;
    in_len    = lens;
    grant     = gr;
    out_ready = ordy;
    rst_n     = rn;
    if (!rn) begin
      for (int k = 0; k < NCH; k++) mq[k].delete();
      m_busy = 0; m_owner = 0; m_left = 0; m_err = 0;
      m_live = 1'b1;
    end else begin
      rdy = m_rdy();
      rq  = m_req();
      if (!m_busy) begin
        if ($countones(gr) > 1) begin
          m_err = 1;
        end else if ($countones(gr) == 1) begin
          for (int k = 0; k < NCH; k++) begin
            if (gr[k] && rq[k]) begin
              m_busy  = 1;
              m_owner = k;
              m_left  = mq[k].pop_front() + 1;
            end
          end
        end
      end else if (ordy) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      for (int k = 0; k < NCH; k++)
        if (iv[k] && rdy[k]) mq[k].push_back(int'(lens[k*LEN_W +: LEN_W]));
    end
    @(posedge clk);
    #1;
    if (m_live) check_outputs();
  endtask

  initial begin
    logic [NCH-1:0] gr, rq;
    logic [31:0]    lens;
    int unsigned    beats, r, a, b, idx;
    bit             ordy;

    in_valid = '0; in_len = '0; grant = '0; out_ready = 1'b0; rst_n = 1'b0;

    // Reset and single beat.
    step('0, 0, '0, 1, 0);
    step('0, 0, '0, 1, 0);
    check("rst_in_ready", in_ready, 8'hFF);
    check("rst_req", req, 8'h00);
    check("rst_err", err, 1'b0);
    step(8'h08, 0, '0, 1, 1);
    check("ch3_req", req, 8'h08);
    step('0, 0, 8'h08, 1, 1);
    check("ch3_valid", out_valid, 1'b1);
    check("ch3_ch", out_ch, 3'd3);
    check("ch3_last", out_last, 1'b1);
    step('0, 0, '0, 1, 1);
    check("ch3_done_valid", out_valid, 1'b0);
    check("ch3_req_drop", req[3], 1'b0);

    // Burst with backpressure on ch5.
    step(8'h20, 32'h0030_0000, '0, 1, 1);
    step('0, 0, 8'h20, 1, 1);
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      ordy = (c % 2 == 0);
      if (out_valid && ordy) beats++;
      step('0, 0, 8'h20, ordy, 1);
    end
    check("ch5_beats", beats, 4);

    // FIFO full on ch0.
    for (int c = 0; c < 5; c++) step(8'h01, 32'h1, '0, 1, 1);
    check("ch0_full", in_ready[0], 1'b0);
    step('0, 0, 8'h01, 1, 1);
    step('0, 0, '0, 1, 1);
    step('0, 0, '0, 1, 1);
    check("ch0_ready_again", in_ready[0], 1'b1);

    // Grant errors: stale then multiple.
    step(8'h03, 0, '0, 1, 0);
    step(8'h03, 0, '0, 1, 1);
    step('0, 0, 8'h40, 1, 1);
    check("stale_err", err, 1'b0);
    check("stale_busy", busy, 1'b0);
    step('0, 0, 8'h03, 1, 1);
    check("multi_err", err, 1'b1);
    check("multi_nobusy", out_valid, 1'b0);
    step('0, 0, '0, 1, 1);
    check("err_sticky", err, 1'b1);

    // Reset mid-burst on ch2.
    step('0, 0, '0, 1, 0);
    step(8'h04, 32'h0000_0700, '0, 1, 1);
    step('0, 0, 8'h04, 1, 1);
    for (int c = 0; c < 3; c++) step('0, 0, '0, 1, 1);
    step('0, 0, '0, 1, 0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_req", req, 8'h00);
    check("abort_ready", in_ready, 8'hFF);

    // All-channel round.
    step(8'hFF, $urandom & 32'h3333_3333, '0, 1, 1);
    for (int k = 0; k < NCH; k++) begin
      step('0, 0, 8'(1 << k), 1, 1);
      check("round_ch", out_ch, k);
      check("round_busy", busy, 1'b1);
      for (int c = 0; c < 20 && m_busy; c++) step('0, 0, 8'($urandom), 1, 1);
      check("round_idle", busy, 1'b0);
    end
    check("round_empty", req, 8'h00);

    // Randomized traffic with an arbiter-like grant source.
    for (int c = 0; c < 3000; c++) begin
      lens = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3333_3333);
      r  = $urandom_range(0, 99);
      rq = m_req();
      gr = '0;
      if (r < 50 && rq != '0) begin
        idx = $urandom_range(0, NCH - 1);
        for (int t = 0; t < NCH; t++) begin
          if (rq[(idx + t) % NCH] && gr == '0) gr[(idx + t) % NCH] = 1'b1;
        end
      end else if (r < 60) begin
        gr = 8'(1 << $urandom_range(0, NCH - 1));
      end else if (r < 63) begin
        a  = $urandom_range(0, NCH - 1);
        b  = (a + 1 + $urandom_range(0, NCH - 2)) % NCH;
        gr = 8'((1 << a) | (1 << b));
      end
      step(8'($urandom & $urandom), lens, gr, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_req_stage_8ch.md
Name: arb_req_stage_8ch

Overview:
- Upstream request-staging stage for the 8-requester hierarchical arbiter (four 2x2 leaf arbiters under one 4x4 root).
- Queues per-channel burst descriptors and presents them to the arbiter as `req[7:0]`.
- Consumes the one-hot `grant[7:0]` and, once a channel is granted, streams that channel's burst as a locked sequence of beats on a single shared output.
- Masks all requests while a burst is in flight, so the arbiter never re-grants mid-burst.

Parameters:
- NCH, 8, number of requester channels; fixed at 8 to match the arbiter width.
- DEPTH, 4, descriptor FIFO depth per channel; power of two, at least 2.
- LEN_W, 4, width of the burst-length field; length is encoded as beats-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  8  per-channel descriptor valid.
- in_ready  out  8  per-channel descriptor ready.
- in_len  in  8*LEN_W  per-channel burst length minus 1; channel i occupies bits [i*LEN_W +: LEN_W].
- req  out  8  request vector to the arbiter.
- grant  in  8  grant vector from the arbiter; one-hot or zero is legal.
- out_valid  out  1  beat valid.
- out_ch  out  3  index of the channel that owns the current beat.
- out_last  out  1  final beat of the burst.
- out_ready  in  1  downstream beat accept.
- busy  out  1  high while in BURST.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: one clock, synchronous, active-low; clock port is `clk`, reset port is `rst_n`.
  - Sampled low on a rising edge: all FIFOs empty, FSM in IDLE, counters cleared, `err` = 0.
  - Reset takes effect from any state, including mid-burst.
  - Reset values of outputs:
    - `in_ready` = 8'hFF (reset clears the FIFOs).
    - `req` = 0, `out_valid` = 0, `out_ch` = 0, `out_last` = 0, `busy` = 0, `err` = 0.
  - An aborted burst is discarded with no further beats.
- Descriptor FIFOs, one per channel, each DEPTH x LEN_W:
  - `in_ready[i]` = (count[i] < DEPTH).
  - Push when `in_valid[i] & in_ready[i]`.
  - Full means `in_ready` low even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leave count unchanged.
  - Pointers wrap modulo DEPTH.
- req:
  - `req[i]` = (state == IDLE) & (count[i] != 0); combinational from registered state.
  - Latency: a push at edge N makes `req[i]` high in cycle N+1.
- FSM states: IDLE, BURST.
  - IDLE, valid grant: exactly one bit `grant[i]` is set and `req[i]` = 1 this cycle.
    - Latch ch = i and cnt = FIFO head len; pop the head.
    - Go to BURST at the next edge, so `out_valid` rises one cycle after the grant is sampled.
  - IDLE, stale grant: a single grant bit on a channel whose `req` is 0 is ignored silently, with no err and no action.
  - IDLE, multiple grant bits: more than one bit set sets `err` (sticky until reset) and nothing is accepted.
  - BURST outputs:
    - `out_valid` = 1, `out_ch` = ch, `out_last` = (cnt == 0), `busy` = 1, `req` = 0.
    - `grant` is ignored entirely.
  - BURST handshake:
    - A beat transfers when `out_valid & out_ready`.
    - If cnt == 0, go to IDLE; otherwise cnt decrements.
    - With `out_ready` low, all outputs hold stable.
  - Return to IDLE: `req` is re-evaluated in the first IDLE cycle; no idle gap is inserted beyond that cycle.
- Burst length: `in_len` = 0 gives 1 beat; maximum is 2^LEN_W beats (16 at default).
- Pushes continue on all channels, including the owning channel, during BURST.

Test Plan:
- Reset and single beat:
  - Reset 2 cycles → `in_ready` = FF, `req` = 0, `err` = 0.
  - Push ch3 len=0, then grant = 8'h08 one cycle → `out_valid` next cycle with `out_ch` = 3 and `out_last` = 1; accepted with `out_ready` = 1; `req[3]` drops.
- Burst with backpressure:
  - Push ch5 len=3, grant ch5, toggle `out_ready` 1,0,1,0,… → exactly 4 beats, `out_last` only on the 4th.
  - `req` = 0 and `busy` = 1 throughout; outputs stable while stalled.
- FIFO full:
  - Push 4 descriptors on ch0 with no grant → `in_ready[0]` = 0.
  - 5th `in_valid` is not accepted.
  - After one grant+burst, `in_ready[0]` = 1 again.
- Grant errors:
  - grant = 8'h03 with `req[1:0]` = 2'b11 → no burst, `err` = 1 and stays high.
  - grant = 8'h40 with `req[6]` = 0 → ignored, no error.
- Reset mid-burst:
  - ch2 len=7; assert `rst_n` = 0 after 3 beats → next cycle `out_valid` = 0, FIFOs empty, `req` = 0.
- All-channel round:
  - Load each channel with 1 descriptor; drive arbiter-model grants to ch0..7 in turn → 8 bursts, `out_ch` sequence 0..7.
  - No grant is accepted while `busy` = 1.
